// File: rtl/fft_peak_detector_if.sv
// Complex bin stream from the streaming FFT: one bin per cycle with i_ce high,
// i_sync marking bin 0 of a frame.
interface fft_peak_detector_if;
  logic        i_ce;
  logic        i_sync;
  logic [15:0] i_result;

  modport master (output i_ce, i_sync, i_result);
  modport slave  (input  i_ce, i_sync, i_result);
endinterface

// File: rtl/fft_peak_detector.sv
// Scans the lower half-spectrum of each FFT frame for the strongest non-DC bin
// and presents it as a packed tone word plus a done level for the control FSM.
module fft_peak_detector #(
  parameter int          N         = 128,
  parameter int          SCAN_BINS = 64,
  parameter int          MIN_BIN   = 1,
  parameter logic [16:0] THRESH    = 17'd1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_enable,
  fft_peak_detector_if.slave  i_fft,
  output logic                o_busy,
  output logic                o_done,
  output logic [6:0]          o_bin,
  output logic [16:0]         o_mag,
  output logic [15:0]         o_tone
);

  localparam int                BIN_W    = $clog2(N);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(SCAN_BINS - 1);
  localparam logic [BIN_W-1:0] FIRST_OK = BIN_W'(MIN_BIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_SCAN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BIN_W-1:0]  r_cnt;
  logic [BIN_W-1:0]  w_cnt_nxt;
  logic [16:0]       r_best_mag;
  logic [16:0]       w_best_mag_nxt;
  logic [BIN_W-1:0]  r_best_bin;
  logic [BIN_W-1:0]  w_best_bin_nxt;
  logic [6:0]        r_bin;
  logic [16:0]       r_mag;
  logic [15:0]       r_tone;

  logic              w_sof;
  logic              w_take;
  logic              w_first;
  logic [BIN_W-1:0]  w_bin;
  logic [16:0]       w_base_mag;
  logic [BIN_W-1:0]  w_base_bin;
  logic              w_detect;

  // Squared magnitude from signed 8x8 products; the worst case (-128,-128)
  // gives 32768, which fits the 17-bit unsigned sum without saturation.
  logic signed [7:0]  w_re;
  logic signed [7:0]  w_im;
  logic signed [15:0] w_re_ext;
  logic signed [15:0] w_im_ext;
  logic signed [15:0] w_re_sq;
  logic signed [15:0] w_im_sq;
  logic [16:0]        w_mag;

  assign w_re     = i_fft.i_result[15:8];
  assign w_im     = i_fft.i_result[7:0];
  assign w_re_ext = 16'(w_re);
  assign w_im_ext = 16'(w_im);
  assign w_re_sq  = w_re_ext * w_re_ext;
  assign w_im_sq  = w_im_ext * w_im_ext;
  assign w_mag    = {1'b0, w_re_sq} + {1'b0, w_im_sq};

  assign w_sof = i_fft.i_ce & i_fft.i_sync;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_take         = 1'b0;
    w_first        = 1'b0;
    w_cnt_nxt      = r_cnt;
    w_best_mag_nxt = r_best_mag;
    w_best_bin_nxt = r_best_bin;

    if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_ARMED;
        S_ARMED,
        S_DONE: begin
          if (w_sof) begin
            w_take  = 1'b1;
            w_first = 1'b1;
          end
        end
        S_SCAN: begin
          if (i_fft.i_ce) begin
            w_take  = 1'b1;
            w_first = i_fft.i_sync;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // A sync beat is bin 0 of a fresh frame: the bests restart from zero.
    w_bin      = w_first ? '0 : r_cnt;
    w_base_mag = w_first ? '0 : r_best_mag;
    w_base_bin = w_first ? '0 : r_best_bin;

    if (w_take) begin
      w_cnt_nxt      = w_bin + BIN_W'(1);
      w_best_mag_nxt = w_base_mag;
      w_best_bin_nxt = w_base_bin;
      if ((w_bin >= FIRST_OK) && (w_mag > w_base_mag)) begin
        w_best_mag_nxt = w_mag;
        w_best_bin_nxt = w_bin;
      end
      w_state_nxt = (w_bin == LAST_BIN) ? S_DONE : S_SCAN;
    end
  end

  assign w_detect = (w_best_mag_nxt >= THRESH);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_best_mag <= '0;
      r_best_bin <= '0;
      r_bin      <= '0;
      r_mag      <= '0;
      r_tone     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_best_mag <= w_best_mag_nxt;
      r_best_bin <= w_best_bin_nxt;
      if (w_state_nxt == S_DONE) begin
        // Results are captured once, on the edge that enters DONE, then held.
        if (r_state != S_DONE) begin
          r_bin  <= 7'(w_best_bin_nxt);
          r_mag  <= w_best_mag_nxt;
          r_tone <= w_detect ? {1'b1, w_best_mag_nxt[16:9], 7'(w_best_bin_nxt)} : 16'h0000;
        end
      end else begin
        r_bin  <= '0;
        r_mag  <= '0;
        r_tone <= '0;
      end
    end
  end

  assign o_busy = (r_state == S_ARMED) || (r_state == S_SCAN);
  assign o_done = (r_state == S_DONE);
  assign o_bin  = r_bin;
  assign o_mag  = r_mag;
  assign o_tone = r_tone;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Self-checking bench for fft_peak_detector: directed spectra for the corner
// cases plus random frames checked against a frame-level peak model.
module tb_fft_peak_detector;

  localparam int N         = 128;
  localparam int SCAN_BINS = 64;
  localparam int MIN_BIN   = 1;
  localparam int THRESH    = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic        o_busy;
  logic        o_done;
  logic [6:0]  o_bin;
  logic [16:0] o_mag;
  logic [15:0] o_tone;

  fft_peak_detector_if u_if ();

  fft_peak_detector #(
    .N         (N),
    .SCAN_BINS (SCAN_BINS),
    .MIN_BIN   (MIN_BIN),
    .THRESH    (17'(THRESH))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_enable (i_enable),
    .i_fft    (u_if),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_bin    (o_bin),
    .o_mag    (o_mag),
    .o_tone   (o_tone)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] frame [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      u_if.i_ce     = 1'b0;
      u_if.i_sync   = 1'($urandom);
      u_if.i_result = 16'($urandom);
      step();
    end
  endtask

  task automatic beat(input logic [15:0] data, input logic sync);
    u_if.i_ce     = 1'b1;
    u_if.i_sync   = sync;
    u_if.i_result = data;
    step();
    u_if.i_ce     = 1'b0;
    u_if.i_sync   = 1'b0;
  endtask

  task automatic check_cleared(input string name);
    check({name, "_busy"}, o_busy, 0);
    check({name, "_done"}, o_done, 0);
    check({name, "_bin"},  o_bin,  0);
    check({name, "_mag"},  o_mag,  0);
    check({name, "_tone"}, o_tone, 0);
  endtask

  task automatic clear_frame();
    for (int b = 0; b < N; b++) frame[b] = 16'h0000;
  endtask

  // Random spectrum: mostly quiet bins, some full-scale, some copies of
  // earlier bins so that equal magnitudes compete.
  task automatic rand_frame(input bit quiet);
    int r;
    for (int b = 0; b < N; b++) begin
      r = $urandom_range(0, 9);
      if (quiet || r < 6)       frame[b] = 16'($urandom) & 16'h0F0F;
      else if (r < 9)           frame[b] = 16'($urandom);
      else if (b > 1)           frame[b] = frame[$urandom_range(1, b - 1)];
      else                      frame[b] = 16'($urandom);
    end
  endtask

  // Reference: strongest bin in [MIN_BIN, SCAN_BINS), first one wins ties.
  task automatic model(output logic [6:0] eb, output logic [16:0] em, output logic [15:0] et);
    int best;
    int bi;
    int re;
    int im;
    int m;
    best = 0;
    bi   = 0;
    for (int b = MIN_BIN; b < SCAN_BINS; b++) begin
      re = $signed(frame[b][15:8]);
      im = $signed(frame[b][7:0]);
      m  = re * re + im * im;
      if (m > best) begin
        best = m;
        bi   = b;
      end
    end
    eb = 7'(bi);
    em = 17'(best);
    et = (best >= THRESH) ? {1'b1, em[16:9], eb} : 16'h0000;
  endtask

  task automatic send_frame(input string name, input int gap, input int nsend,
                            input logic [6:0] eb, input logic [16:0] em, input logic [15:0] et);
    for (int b = 0; b < nsend; b++) begin
      beat(frame[b], b == 0);
      if (b == 0) begin
        check({name, "_done_drop"}, o_done, 0);
        check({name, "_tone_clr"},  o_tone, 0);
      end
      if (b == SCAN_BINS - 2) check({name, "_done_early"}, o_done, 0);
      if (b == SCAN_BINS - 1) begin
        check({name, "_done"}, o_done, 1);
        check({name, "_busy"}, o_busy, 0);
        check({name, "_bin"},  o_bin,  eb);
        check({name, "_mag"},  o_mag,  em);
        check({name, "_tone"}, o_tone, et);
      end
      idle(gap);
    end
    if (nsend > SCAN_BINS) begin
      check({name, "_hold_done"}, o_done, 1);
      check({name, "_hold_tone"}, o_tone, et);
      check({name, "_hold_bin"},  o_bin,  eb);
    end
  endtask

  logic [6:0]  exp_bin;
  logic [16:0] exp_mag;
  logic [15:0] exp_tone;

  initial begin
    rst           = 1'b1;
    i_enable      = 1'b0;
    u_if.i_ce     = 1'b0;
    u_if.i_sync   = 1'b0;
    u_if.i_result = 16'h0000;
    repeat (3) step();
    check_cleared("reset");

    rst      = 1'b0;
    i_enable = 1'b1;
    step();
    check("armed_busy", o_busy, 1);
    check("armed_done", o_done, 0);

    clear_frame();
    frame[0]  = 16'h7F00;
    frame[10] = 16'h281E;
    send_frame("tone", 0, SCAN_BINS + 2, 7'd10, 17'd2500, 16'h820A);

    clear_frame();
    frame[5] = 16'h1400;
    send_frame("below", 0, SCAN_BINS, 7'd5, 17'd400, 16'h0000);

    clear_frame();
    frame[3] = 16'hE000;
    frame[7] = 16'hE000;
    send_frame("tie", 1, SCAN_BINS, 7'd3, 17'd1024, 16'h8103);

    clear_frame();
    frame[0]  = 16'h7F7F;
    frame[63] = 16'h8080;
    frame[64] = 16'h7F7F;
    send_frame("extreme", 0, N, 7'd63, 17'd32768, 16'hA03F);

    // Reset while holding results clears them and overrides enable.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_cleared("rst_done");
    step();

    clear_frame();
    frame[12] = 16'h6464;
    for (int b = 0; b < 20; b++) beat(frame[b], b == 0);
    clear_frame();
    frame[9] = 16'h281E;
    send_frame("resync", 0, SCAN_BINS, 7'd9, 17'd2500, 16'h8209);

    // Drop enable on the bin-30 beat, then a sparse frame.
    rand_frame(1'b0);
    for (int b = 0; b < 30; b++) beat(frame[b], b == 0);
    i_enable = 1'b0;
    beat(frame[30], 1'b0);
    check_cleared("abort_en");
    i_enable = 1'b1;
    step();
    rand_frame(1'b0);
    model(exp_bin, exp_mag, exp_tone);
    send_frame("after_en", 3, SCAN_BINS, exp_bin, exp_mag, exp_tone);

    // Reset pulsed on the bin-30 beat, then a sparse frame.
    rand_frame(1'b0);
    for (int b = 0; b < 30; b++) beat(frame[b], b == 0);
    rst = 1'b1;
    beat(frame[30], 1'b0);
    rst = 1'b0;
    check_cleared("abort_rst");
    step();
    rand_frame(1'b0);
    model(exp_bin, exp_mag, exp_tone);
    send_frame("after_rst", 3, SCAN_BINS, exp_bin, exp_mag, exp_tone);

    i_enable = 1'b0;
    step();
    check_cleared("disable_done");

    // Sync arriving with the enable edge must not start a scan.
    i_enable      = 1'b1;
    u_if.i_ce     = 1'b1;
    u_if.i_sync   = 1'b1;
    u_if.i_result = 16'h7F7F;
    step();
    for (int b = 1; b < SCAN_BINS; b++) beat(16'h7F7F, 1'b0);
    check("en_sync_done", o_done, 0);
    check("en_sync_busy", o_busy, 1);

    for (int i = 0; i < 6; i++) begin
      rand_frame(i % 3 == 0);
      model(exp_bin, exp_mag, exp_tone);
      send_frame($sformatf("rand%0d", i), $urandom_range(0, 3),
                 SCAN_BINS + $urandom_range(0, 4), exp_bin, exp_mag, exp_tone);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_peak_detector.md
# fft_peak_detector

Downstream consumer of the streaming FFT output inside the FPGA control path. It takes the complex bin stream (`o_result`/`o_sync`, qualified by the shared chip-enable), computes a squared magnitude per bin, and scans the lower half-spectrum for the strongest non-DC bin. It then presents a packed 16-bit tone word plus a done flag that the control FSM copies into the I2C Results registers.

## Interface
- `N`, 128: FFT frame length in bins; bin counter width is clog2(N)=7.
- `SCAN_BINS`, 64: number of bins scanned per frame, counted from bin 0; must be ≤ N.
- `MIN_BIN`, 1: lowest bin eligible for peak; bins below it (DC) are ignored.
- `THRESH`, 17'd1024: minimum squared magnitude (inclusive) for a detection.
- `clk` in 1: system clock; everything samples on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `i_enable` in 1: arms the detector; low forces IDLE.
- `i_ce` in 1: FFT chip-enable; one bin is transferred per cycle with `i_ce`=1.
- `i_sync` in 1: marks bin 0 of a frame; valid only when `i_ce`=1.
- `i_result` in 16: `{re[7:0], im[7:0]}`, both two's complement.
- `o_busy` out 1: high in ARMED or SCAN.
- `o_done` out 1: high in DONE; result outputs are valid.
- `o_bin` out 7: index of the peak bin.
- `o_mag` out 17: squared magnitude of the peak, re²+im².
- `o_tone` out 16: `{detected, o_mag[16:9], o_bin}` when detected; 16'h0000 otherwise.

## Operation
- Squared magnitude: `mag = re*re + im*im`, computed from signed 8×8 products into a 17-bit unsigned result. The maximum is 32768 (re=im=-128). No saturation is needed.
- States:
  - IDLE → ARMED when `i_enable`=1.
  - ARMED: waits for `i_ce & i_sync`. That beat is bin 0 and moves the FSM to SCAN.
  - SCAN: each `i_ce` beat increments the bin counter. After the beat carrying bin `SCAN_BINS-1` is processed, the FSM moves to DONE.
  - DONE: holds all results.
- Peak rule:
  - A bin is a candidate if `bin ≥ MIN_BIN` and `mag > best_mag`. Comparison is strict, so the lowest index wins ties.
  - `best_mag` and `best_bin` are cleared to 0 on entry to SCAN.
- Detection: `detected = (best_mag ≥ THRESH)`, evaluated when entering DONE.
  - `o_bin` and `o_mag` always report the best candidate, even when not detected.
  - `o_tone` is zero when `detected`=0.
- Beats with `i_ce`=0 are ignored in every state. Bins at or above `SCAN_BINS` are ignored and are not counted.
- Resync: `i_ce & i_sync` while in SCAN restarts the scan. That beat is treated as bin 0 and the bests are cleared.
- Restart from DONE: `i_ce & i_sync` with `i_enable`=1 re-enters SCAN. `o_done` drops in the same cycle the state leaves DONE, and results clear.
- `i_enable`=0 in any state → IDLE next cycle, with all outputs cleared.
- `rst`=1 → IDLE. Every output resets to 0 (`o_busy`=0, `o_done`=0, `o_bin`=0, `o_mag`=0, `o_tone`=0). Reset is honoured mid-scan and overrides every other input.

## Timing
- A bin is consumed on the rising edge where `i_ce`=1. The compare/update takes effect the same edge, with no pipeline stage.
- `o_done` rises on the edge that registers bin `SCAN_BINS-1`. `o_tone`, `o_bin` and `o_mag` are valid in the same cycle `o_done` first reads 1.
- Latency from the last scanned beat to `o_done` is one clock.
- `o_done` is a level: it stays high until restart, `i_enable`=0, or `rst`.
- `i_ce` may pulse every cycle or sparsely (e.g. 1-in-4); results must be identical for the same beat sequence.
- `i_sync` without `i_ce` is ignored.
- `i_enable` rising and a sync beat in the same cycle: the sync is ignored. ARMED must be reached first.

## Test plan
- **Single tone.** Frame with bin 0 = {127,0} and bin 10 = {40,30}, all others zero → `o_mag`=2500, `o_bin`=10, `o_tone`=16'h820A, `o_done` one clock after the bin-63 beat.
- **Below threshold.** Only bin 5 = {20,0} non-zero → `o_mag`=400, `o_bin`=5, `o_tone`=16'h0000, `o_done`=1.
- **Tie and inclusive threshold.** Bins 3 and 7 each = {-32,0} → `o_mag`=1024, `o_bin`=3, `o_tone`=16'h8103.
- **Extreme value and scan limit.** Bin 63 = {-128,-128} and bin 64 = {127,127} → `o_bin`=63, `o_mag`=32768, `o_tone`=16'hA03F. Bin 64 is ignored.
- **Resync.** New `i_sync` at bin 20 of a frame whose bin 12 was large, with the new frame's bin 9 = {40,30} → result reflects the new frame only: `o_tone`=16'h8209.
- **Abort.** `i_enable` dropped at bin 30, or `rst` pulsed at bin 30 → IDLE next clock, all outputs 0. The next enabled frame is detected normally, with `i_ce` at 1-in-4 spacing.
